// File: rtl/cpu_step_ctrl_if.sv
// Button/halt inputs and advance/status outputs of the run/step controller.
interface cpu_step_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [1:0]       btn;
  logic             halt;
  logic             cpu_en;
  logic             running;
  logic             halted;
  logic [CNT_W-1:0] stepcnt;

  modport master (
    output btn,
    output halt,
    input  cpu_en,
    input  running,
    input  halted,
    input  stepcnt
  );

  modport slave (
    input  btn,
    input  halt,
    output cpu_en,
    output running,
    output halted,
    output stepcnt
  );
endinterface

// File: rtl/cpu_step_ctrl.sv
// Run/step controller: issues one-cycle core advance pulses on single step or at a
// divided rate while running, stops for good on core halt, and counts the pulses.
module cpu_step_ctrl #(
  parameter int RUN_DIV = 5000000,
  parameter int CNT_W   = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  cpu_step_ctrl_if.slave     io_bus
);

  localparam int DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

  typedef enum logic [1:0] {
    ST_STOP   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] w_div_nxt;
  logic             r_cpu_en;
  logic             w_cpu_en_nxt;
  logic             r_running;
  logic             r_halted;
  logic [CNT_W-1:0] r_stepcnt;
  logic             w_tc;
  logic             w_toggle;
  logic             w_step;

  assign w_toggle = io_bus.btn[0];
  assign w_step   = io_bus.btn[1];
  assign w_tc     = (r_div == DIV_LAST);

  // Halt outranks everything, then the toggle; a pulse is only decided here and
  // appears on the registered output the following cycle.
  always_comb begin
    w_state_nxt  = r_state;
    w_div_nxt    = '0;
    w_cpu_en_nxt = 1'b0;
    case (r_state)
      ST_STOP: begin
        if (io_bus.halt) begin
          w_state_nxt = ST_HALTED;
        end else if (w_toggle) begin
          w_state_nxt = ST_RUN;
        end else if (w_step) begin
          w_cpu_en_nxt = 1'b1;
        end
      end
      ST_RUN: begin
        if (io_bus.halt) begin
          w_state_nxt = ST_HALTED;
        end else if (w_toggle) begin
          w_state_nxt = ST_STOP;
        end else begin
          w_div_nxt    = w_tc ? '0 : r_div + DIV_W'(1);
          w_cpu_en_nxt = w_tc;
        end
      end
      ST_HALTED: begin
        w_state_nxt = ST_HALTED;
      end
      default: begin
        w_state_nxt = ST_STOP;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= ST_STOP;
      r_div     <= '0;
      r_cpu_en  <= 1'b0;
      r_running <= 1'b0;
      r_halted  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_div     <= w_div_nxt;
      r_cpu_en  <= w_cpu_en_nxt;
      r_running <= (w_state_nxt == ST_RUN);
      r_halted  <= (w_state_nxt == ST_HALTED);
    end
  end

  // Counts pulses already on the output, so the display lags CPU_EN by one cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_stepcnt <= '0;
    end else if (r_cpu_en) begin
      r_stepcnt <= r_stepcnt + CNT_W'(1);
    end
  end

  assign io_bus.cpu_en  = r_cpu_en;
  assign io_bus.running = r_running;
  assign io_bus.halted  = r_halted;
  assign io_bus.stepcnt = r_stepcnt;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed and randomized bench for cpu_step_ctrl against a cycle-time reference model.
module tb_cpu_step_ctrl;

  localparam int RUN_DIV = 4;
  localparam int CNT_W   = 4;

  logic clk = 1'b0;
  logic rstN;

  always #5 clk = ~clk;

  cpu_step_ctrl_if #(.CNT_W(CNT_W)) bus ();

  cpu_step_ctrl #(.RUN_DIV(RUN_DIV), .CNT_W(CNT_W)) dut (
    .i_clk   (clk),
    .i_rst_n (rstN),
    .io_bus  (bus)
  );

  typedef enum {M_STOP, M_RUN, M_HALTED} mode_t;

  mode_t       mMode = M_STOP;
  int          mRunStart = 0;
  bit          mEn = 1'b0;
  int unsigned mCnt = 0;
  int          cyc = 0;
  int          compared = 0;
  int          mismatched = 0;

  task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, ".cpu_en"},  32'(bus.cpu_en),  32'(mEn));
    checkValue({tag, ".running"}, 32'(bus.running), 32'(mMode == M_RUN));
    checkValue({tag, ".halted"},  32'(bus.halted),  32'(mMode == M_HALTED));
    checkValue({tag, ".stepcnt"}, 32'(bus.stepcnt), mCnt % (1 << CNT_W));
  endtask

  // Inputs are held for one cycle, sampled at the next edge; the model then predicts
  // the outputs of the cycle that edge starts. Run advances fall every RUN_DIV cycles
  // counted from the first cycle spent running.
  task automatic applyStimulus(input logic [1:0] btn, input logic halt, input logic rstIn, input string tag);
    bit newEn;
    bus.btn  = btn;
    bus.halt = halt;
    rstN     = rstIn;
    @(posedge clk);
    #1;
    cyc++;
    if (!rstIn) begin
      mMode = M_STOP;
      mEn   = 1'b0;
      mCnt  = 0;
    end else begin
      mCnt  = (mCnt + 32'(mEn)) % (1 << CNT_W);
      newEn = 1'b0;
      if (mMode != M_HALTED) begin
        if (halt) begin
          mMode = M_HALTED;
        end else if (mMode == M_STOP) begin
          if (btn[0]) begin
            mMode     = M_RUN;
            mRunStart = cyc;
          end else if (btn[1]) begin
            newEn = 1'b1;
          end
        end else begin
          if (btn[0]) mMode = M_STOP;
          else if ((cyc - mRunStart) % RUN_DIV == 0) newEn = 1'b1;
        end
      end
      mEn = newEn;
    end
    checkOutput(tag);
    bus.btn = 2'b00;
  endtask

  task automatic idle(input int n, input string tag);
    repeat (n) applyStimulus(2'b00, 1'b0, 1'b1, tag);
  endtask

  task automatic doReset(input int n);
    repeat (n) applyStimulus(2'b00, 1'b0, 1'b0, "reset");
  endtask

  initial begin
    bus.btn  = 2'b00;
    bus.halt = 1'b0;
    rstN     = 1'b0;

    $display("[TB] reset then single step");
    doReset(3);
    checkValue("resetCnt", 32'(bus.stepcnt), 0);
    idle(2, "preStep");
    applyStimulus(2'b10, 1'b0, 1'b1, "stepPulse");
    checkValue("stepLatency", 32'(bus.cpu_en), 1);
    idle(1, "stepAfter");
    checkValue("stepOnce", 32'(bus.cpu_en), 0);
    checkValue("stepCnt", 32'(bus.stepcnt), 1);
    checkValue("stepNotRunning", 32'(bus.running), 0);
    idle(2, "stepIdle");

    $display("[TB] run, then stop on the cycle of the third advance");
    doReset(1);
    idle(2, "preRun");
    applyStimulus(2'b01, 1'b0, 1'b1, "runToggle");
    checkValue("runEntered", 32'(bus.running), 1);
    idle(12, "runCadence");
    checkValue("thirdAdvance", 32'(bus.cpu_en), 1);
    applyStimulus(2'b01, 1'b0, 1'b1, "stopToggle");
    checkValue("stopNoEn", 32'(bus.cpu_en), 0);
    checkValue("stopRunning", 32'(bus.running), 0);
    idle(1, "stopSettle");
    checkValue("stopCnt", 32'(bus.stepcnt), 3);
    idle(6, "stopQuiet");

    $display("[TB] stop at divider terminal count");
    applyStimulus(2'b01, 1'b0, 1'b1, "runAgain");
    idle(3, "toTerminal");
    applyStimulus(2'b01, 1'b0, 1'b1, "stopAtTc");
    checkValue("stopAtTcNoEn", 32'(bus.cpu_en), 0);
    idle(5, "afterTcStop");

    $display("[TB] simultaneous buttons and step while running");
    applyStimulus(2'b11, 1'b0, 1'b1, "bothInStop");
    checkValue("bothRunning", 32'(bus.running), 1);
    checkValue("bothNoEn", 32'(bus.cpu_en), 0);
    idle(2, "runPreStep");
    applyStimulus(2'b10, 1'b0, 1'b1, "stepInRun");
    idle(3, "runPostStep");
    applyStimulus(2'b10, 1'b0, 1'b1, "stepInRunTc");
    idle(6, "runCadence2");

    $display("[TB] halt priority");
    applyStimulus(2'b00, 1'b1, 1'b1, "haltInRun");
    checkValue("haltedFlag", 32'(bus.halted), 1);
    applyStimulus(2'b01, 1'b0, 1'b1, "haltedToggle");
    applyStimulus(2'b10, 1'b0, 1'b1, "haltedStep");
    idle(5, "haltedIdle");
    doReset(1);
    checkValue("haltResetHalted", 32'(bus.halted), 0);
    applyStimulus(2'b10, 1'b1, 1'b1, "haltWithStep");
    checkValue("haltStepNoEn", 32'(bus.cpu_en), 0);
    checkValue("haltStepHalted", 32'(bus.halted), 1);
    applyStimulus(2'b11, 1'b1, 1'b1, "haltedBoth");
    idle(3, "haltedIdle2");
    doReset(1);
    checkValue("releaseRunning", 32'(bus.running), 0);

    $display("[TB] counter wrap");
    for (int i = 1; i <= 17; i++) begin
      applyStimulus(2'b10, 1'b0, 1'b1, "wrapStep");
      idle(1, "wrapGap");
      checkValue("wrapCnt", 32'(bus.stepcnt), 32'(i % 16));
    end

    $display("[TB] reset mid-run at divider terminal count");
    applyStimulus(2'b01, 1'b0, 1'b1, "midRunEnter");
    idle(7, "midRun");
    applyStimulus(2'b00, 1'b0, 1'b0, "midRunReset");
    checkValue("midResetNoEn", 32'(bus.cpu_en), 0);
    checkValue("midResetRunning", 32'(bus.running), 0);
    checkValue("midResetCnt", 32'(bus.stepcnt), 0);
    idle(3, "postMidReset");

    $display("[TB] randomized traffic");
    begin
      logic haltLvl = 1'b0;
      for (int i = 0; i < 800; i++) begin
        logic [1:0] b;
        logic       r;
        b[0] = ($urandom_range(0, 9) == 0);
        b[1] = ($urandom_range(0, 4) == 0);
        if ($urandom_range(0, 149) == 0) haltLvl = ~haltLvl;
        r = ($urandom_range(0, 119) != 0);
        applyStimulus(b, haltLvl, r, "random");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
